ahb_arbiter_slave: RTL and testbench
====================================

Name: ahb_arbiter_slave

Overview:
- Per-slave arbiter directly downstream of the per-master address decoders.
- Collects the one-bit hreq destined for this slave from every master's decoder.
- Picks one owner per address phase, round-robin; holds the owner across bursts and locked sequences.
- Drives the slave's hsel and the address-phase / data-phase master mux selects used by the interconnect; stalls requesting masters that are not granted.

Parameters:
SLAVE_X_MASTER_NUM, 3, number of masters that can reach this slave (>=2)
MASTER_ID_WIDTH, 2, width of a master index; must be >= $clog2(SLAVE_X_MASTER_NUM)

Ports:
hclk  input  1  bus clock
hreset_n  input  1  synchronous active-low reset, sampled on rising hclk
hreq  input  SLAVE_X_MASTER_NUM  bit i = master i's decoder request for this slave (already gated by htrans!=IDLE)
htrans_m  input  SLAVE_X_MASTER_NUM x htrans_type  current htrans of each master
hlock_m  input  SLAVE_X_MASTER_NUM  master i requests bus hold after current beat
hready  input  1  hreadyout of this slave
hgrant  output  SLAVE_X_MASTER_NUM  one-hot address-phase owner, registered
hsel  output  1  slave select for current address phase
haddr_sel  output  MASTER_ID_WIDTH  address/control mux index
hdata_sel  output  MASTER_ID_WIDTH  write-data/response mux index
hdata_valid  output  1  a data phase for this slave is in progress
hwait_m  output  SLAVE_X_MASTER_NUM  stall to master i: requesting but not owner

Behaviour:
- Interface: one clock hclk; reset hreset_n is synchronous and active-low.
- Reset values: hgrant=0, hsel=0, haddr_sel=0, hdata_sel=0, hdata_valid=0, FSM=ARB_IDLE, rr_ptr=SLAVE_X_MASTER_NUM-1 (master 0 wins first). Reset mid-transfer aborts ownership immediately; there is no drain.
- FSM states:
  - ARB_IDLE: no owner.
  - ARB_ADDR: owner, unlocked.
  - ARB_BURST: owner, held.
- All FSM / owner / rr_ptr updates happen only on cycles with hready=1. With hready=0, every register holds, including the data-phase registers.
- Hold condition: hold = hlock_m[owner] | htrans_m[owner]==SEQ | htrans_m[owner]==BUSY.
- Transitions (hready=1):
  - ARB_IDLE: if |hreq, winner = first set bit searching from rr_ptr+1 upward with wrap → ARB_ADDR, owner=winner, rr_ptr=winner. Otherwise stay.
  - ARB_ADDR/ARB_BURST with hold → ARB_BURST, same owner.
  - ARB_ADDR/ARB_BURST without hold: if |hreq, rearbitrate as in ARB_IDLE → ARB_ADDR. The current owner is eligible only if no other master requests (fairness). If no hreq → ARB_IDLE.
- Grant latency: hgrant, haddr_sel = registered owner, so effective one cycle after the winning request is sampled.
- hsel = (state!=ARB_IDLE) & hreq[owner]. This is combinational from the registered owner.
- Data-phase pipeline: on hready=1, hdata_sel<=haddr_sel and hdata_valid<=hsel. A one-cycle address→data latency.
- hwait_m[i] = hreq[i] & ~hgrant[i], combinational.
- Simultaneous requests: round-robin order only. There is no fixed priority.
- Owner drops hreq while in ARB_BURST without hold: treated as end of burst; rearbitrate.
- Wrap-around: the rr search wraps from SLAVE_X_MASTER_NUM-1 to 0.
- Index outputs never exceed SLAVE_X_MASTER_NUM-1.

Decomposition:
- AHB_package holds htrans_type (existing) and adds arb_state_type {ARB_IDLE, ARB_ADDR, ARB_BURST}.
- Sub-module ahb_rr_picker (combinational): inputs req vector and rr_ptr; outputs found and winner index.

Test Plan:
- Reset then hreq=3'b000 for 5 cycles → hgrant=0, hsel=0, state ARB_IDLE, hdata_valid=0.
- hreq=3'b111, htrans_m all NONSEQ, hlock_m=0, hready=1, held 6 cycles → hgrant sequence 001,010,100,001,010 starting one cycle after the request. hdata_sel follows haddr_sel one cycle later.
- Master1 owns; htrans_m[1]=NONSEQ,SEQ,BUSY,SEQ with hreq=3'b011 → hgrant stays 010 through all four beats, then moves to 001 after the first non-SEQ/BUSY beat.
- Master2 owns with hready=0 for 3 cycles while hreq=3'b101 → hgrant, haddr_sel, hdata_sel, hdata_valid frozen. hwait_m=3'b001 throughout.
- hlock_m[0]=1 with htrans_m[0]=NONSEQ, hreq=3'b011 → master 0 retained (ARB_BURST). Lock drops → master 1 granted next hready cycle.
- hreset_n=0 asserted during master 2 burst → next edge: hgrant=0, hdata_valid=0. After release with hreq=3'b110 → master 1 wins first.

Source files
------------

// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared AHB types for the per-slave arbiter: transfer type and arbiter FSM state.
package ahb_arbiter_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ADDR  = 2'b01,
    ARB_BURST = 2'b10
  } arb_state_type;

endpackage

// File: rtl/ahb_arbiter_slave_rr.sv
// Round-robin picker: first set request strictly after rr_ptr, wrapping to 0.
module ahb_rr_picker #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0] cand;

  // The previous winner is visited last, so it only wins again when alone.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(rr_ptr) + i) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: round-robin owner selection with burst/lock hold,
// address- and data-phase master mux selects, and per-master stall.
//
// state     | meaning
// ARB_IDLE  | no owner
// ARB_ADDR  | owner granted, may be rearbitrated next ready cycle
// ARB_BURST | owner held by SEQ/BUSY or hlock
module ahb_arbiter_slave
  import ahb_arbiter_slave_pkg::*;
#(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int MASTER_ID_WIDTH    = 2
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
  input  htrans_type                    htrans_m [SLAVE_X_MASTER_NUM],
  input  logic [SLAVE_X_MASTER_NUM-1:0] hlock_m,
  input  logic                          hready,
  output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
  output logic                          hsel,
  output logic [MASTER_ID_WIDTH-1:0]    haddr_sel,
  output logic [MASTER_ID_WIDTH-1:0]    hdata_sel,
  output logic                          hdata_valid,
  output logic [SLAVE_X_MASTER_NUM-1:0] hwait_m
);

  arb_state_type              state_q, state_d;
  logic [MASTER_ID_WIDTH-1:0] owner_q, owner_d;
  logic [MASTER_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [MASTER_ID_WIDTH-1:0] hdata_sel_q, hdata_sel_d;
  logic                       hdata_valid_q, hdata_valid_d;

  logic                       hold;
  logic                       pick_found;
  logic [MASTER_ID_WIDTH-1:0] pick_winner;

  ahb_rr_picker #(
    .N (SLAVE_X_MASTER_NUM),
    .W (MASTER_ID_WIDTH)
  ) u_picker (
    .req    (hreq),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign hold = hlock_m[owner_q]
              | (htrans_m[owner_q] == SEQ)
              | (htrans_m[owner_q] == BUSY);

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= MASTER_ID_WIDTH'(SLAVE_X_MASTER_NUM - 1);
      hdata_sel_q   <= '0;
      hdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      hdata_sel_q   <= hdata_sel_d;
      hdata_valid_q <= hdata_valid_d;
    end
  end

  // Everything, data-phase pipeline included, advances only on ready cycles.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    hdata_sel_d   = hdata_sel_q;
    hdata_valid_d = hdata_valid_q;
    if (hready) begin
      hdata_sel_d   = owner_q;
      hdata_valid_d = hsel;
      if ((state_q != ARB_IDLE) && hold) begin
        state_d = ARB_BURST;
      end else if (pick_found) begin
        state_d  = ARB_ADDR;
        owner_d  = pick_winner;
        rr_ptr_d = pick_winner;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_comb begin
    hgrant = '0;
    if (state_q != ARB_IDLE) hgrant[owner_q] = 1'b1;
    hsel    = (state_q != ARB_IDLE) & hreq[owner_q];
    hwait_m = hreq & ~hgrant;
  end

  assign haddr_sel   = owner_q;
  assign hdata_sel   = hdata_sel_q;
  assign hdata_valid = hdata_valid_q;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed vector bench for ahb_arbiter_slave with 3 masters.
module tb_ahb_arbiter_slave;
  import ahb_arbiter_slave_pkg::*;

  localparam logic [1:0] T_I = 2'b00, T_B = 2'b01, T_N = 2'b10, T_S = 2'b11;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [2:0] hreq;
  htrans_type htrans_m [3];
  logic [2:0] hlock_m;
  logic       hready;
  logic [2:0] hgrant;
  logic       hsel;
  logic [1:0] haddr_sel;
  logic [1:0] hdata_sel;
  logic       hdata_valid;
  logic [2:0] hwait_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_slave #(
    .SLAVE_X_MASTER_NUM (3),
    .MASTER_ID_WIDTH    (2)
  ) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .hreq        (hreq),
    .htrans_m    (htrans_m),
    .hlock_m     (hlock_m),
    .hready      (hready),
    .hgrant      (hgrant),
    .hsel        (hsel),
    .haddr_sel   (haddr_sel),
    .hdata_sel   (hdata_sel),
    .hdata_valid (hdata_valid),
    .hwait_m     (hwait_m)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic [5:0] trans;
    logic [2:0] lock;
    logic       rdy;
    logic [2:0] grant;
    logic [1:0] asel;
    logic [1:0] dsel;
    logic       dv;
    logic       sel;
    logic [2:0] wt;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic rst_n, logic [2:0] req, logic [5:0] trans,
                              logic [2:0] lock, logic rdy, logic [2:0] grant,
                              logic [1:0] asel, logic [1:0] dsel, logic dv,
                              logic sel, logic [2:0] wt);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.trans = trans; v.lock = lock; v.rdy = rdy;
    v.grant = grant; v.asel = asel; v.dsel = dsel; v.dv = dv; v.sel = sel; v.wt = wt;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare registered and combinational outputs.
  task automatic run_vec(int idx, vec_t v);
    hreset_n = v.rst_n;
    hreq     = v.req;
    hlock_m  = v.lock;
    hready   = v.rdy;
    for (int m = 0; m < 3; m++) htrans_m[m] = htrans_type'(v.trans[2*m +: 2]);
    @(posedge hclk);
    #1;
    check("hgrant",      idx, 8'(hgrant),      8'(v.grant));
    check("haddr_sel",   idx, 8'(haddr_sel),   8'(v.asel));
    check("hdata_sel",   idx, 8'(hdata_sel),   8'(v.dsel));
    check("hdata_valid", idx, 8'(hdata_valid), 8'(v.dv));
    check("hsel",        idx, 8'(hsel),        8'(v.sel));
    check("hwait_m",     idx, 8'(hwait_m),     8'(v.wt));
  endtask

  initial begin
    hreset_n = 1'b0;
    hreq     = '0;
    hlock_m  = '0;
    hready   = 1'b1;
    for (int m = 0; m < 3; m++) htrans_m[m] = IDLE;

    // reset, then idle
    vecs.push_back(mk(0, 3'b000, {T_I,T_I,T_I}, 3'b000, 1, 3'b000, 0, 0, 0, 0, 3'b000));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 3'b000, {T_I,T_I,T_I}, 3'b000, 1, 3'b000, 0, 0, 0, 0, 3'b000));
    // all three request: round-robin rotation, data select trails by one cycle
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b001, 0, 0, 0, 1, 3'b110));
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b010, 1, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b100, 2, 1, 1, 1, 3'b011));
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b001, 0, 2, 1, 1, 3'b110));
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b010, 1, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 3'b111, {T_N,T_N,T_N}, 3'b000, 1, 3'b100, 2, 1, 1, 1, 3'b011));
    // master 1 burst NONSEQ, SEQ, BUSY, SEQ, then new NONSEQ lets master 0 in
    vecs.push_back(mk(1, 3'b010, {T_I,T_N,T_I}, 3'b000, 1, 3'b010, 1, 2, 0, 1, 3'b000));
    vecs.push_back(mk(1, 3'b011, {T_I,T_S,T_N}, 3'b000, 1, 3'b010, 1, 1, 1, 1, 3'b001));
    vecs.push_back(mk(1, 3'b011, {T_I,T_B,T_N}, 3'b000, 1, 3'b010, 1, 1, 1, 1, 3'b001));
    vecs.push_back(mk(1, 3'b011, {T_I,T_S,T_N}, 3'b000, 1, 3'b010, 1, 1, 1, 1, 3'b001));
    vecs.push_back(mk(1, 3'b011, {T_I,T_N,T_N}, 3'b000, 1, 3'b001, 0, 1, 1, 1, 3'b010));
    // master 2 takes over, then slave stalls for 3 cycles
    vecs.push_back(mk(1, 3'b100, {T_N,T_I,T_I}, 3'b000, 1, 3'b100, 2, 0, 0, 1, 3'b000));
    vecs.push_back(mk(1, 3'b100, {T_S,T_I,T_I}, 3'b000, 1, 3'b100, 2, 2, 1, 1, 3'b000));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 3'b101, {T_N,T_I,T_N}, 3'b000, 0, 3'b100, 2, 2, 1, 1, 3'b001));
    vecs.push_back(mk(1, 3'b101, {T_N,T_I,T_N}, 3'b000, 1, 3'b001, 0, 2, 1, 1, 3'b100));
    // master 0 locked, then lock released
    vecs.push_back(mk(1, 3'b011, {T_I,T_N,T_N}, 3'b001, 1, 3'b001, 0, 0, 1, 1, 3'b010));
    vecs.push_back(mk(1, 3'b011, {T_I,T_N,T_N}, 3'b001, 1, 3'b001, 0, 0, 1, 1, 3'b010));
    vecs.push_back(mk(1, 3'b011, {T_I,T_N,T_N}, 3'b000, 1, 3'b010, 1, 0, 1, 1, 3'b001));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // reset in the middle of a master 2 burst, then fresh arbitration from master 0
    run_vec(100, mk(1, 3'b100, {T_N,T_I,T_I}, 3'b000, 1, 3'b100, 2, 1, 0, 1, 3'b000));
    run_vec(101, mk(1, 3'b100, {T_S,T_I,T_I}, 3'b000, 1, 3'b100, 2, 2, 1, 1, 3'b000));
    run_vec(102, mk(0, 3'b100, {T_S,T_I,T_I}, 3'b000, 1, 3'b000, 0, 0, 0, 0, 3'b100));
    run_vec(103, mk(1, 3'b110, {T_N,T_N,T_I}, 3'b000, 1, 3'b010, 1, 0, 0, 1, 3'b100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
